aline_acq_pingpong: RTL and testbench

//  Parametrised A-line acquisition engine: syncs ADC capture to the sweep trigger, stores NSAMPLES/A-line
//  in a 2-bank ping-pong RAM and streams finished A-lines out with a valid/ready handshake.

---
 rtl/aline_acq_pingpong_pkg.sv | 7 +
 rtl/aline_acq_pingpong_dpram.sv | 19 +
 rtl/aline_acq_pingpong.sv | 113 +++++++++++
 tb/tb_aline_acq_pingpong.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aline_acq_pingpong_pkg.sv
// aline_acq_pingpong_pkg: writer/reader state encodings and default sizes for the A-line engine
package aline_acq_pingpong_pkg;
  localparam int DEF_DATA_W = 14;
  localparam int DEF_NSAMPLES = 1170;
  typedef enum logic [1:0] {W_IDLE, W_DELAY, W_CAPTURE} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;
endpackage

// File: rtl/aline_acq_pingpong_dpram.sv
// aline_dpram: simple dual-port RAM, one write port and one registered read port with read enable
module aline_dpram #(
  parameter int DATA_W = 14,
  parameter int AW = 12
) (
  input  logic              clk_system,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clk_system) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/aline_acq_pingpong.sv
// aline_acq_pingpong: trigger-synced A-line capture into a 2-bank ping-pong RAM, streamed out valid/ready
module aline_acq_pingpong
  import aline_acq_pingpong_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NSAMPLES = DEF_NSAMPLES,
  parameter int ADDR_W = 11,
  parameter int DLY_W = 8,
  parameter int OVR_W = 16
) (
  input  logic              clk_system,
  input  logic              global_reset,
  input  logic              enable,
  input  logic              trigger,
  input  logic [DLY_W-1:0]  trig_delay,
  input  logic              fmt_offset,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic [ADDR_W-1:0] sample_pos,
  output logic              acq_busy,
  output logic [OVR_W-1:0]  overrun_cnt
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NSAMPLES - 1);
  wstate_t ws;
  rstate_t rs;
  logic trig_d, wbank, rbank, fmt_lat;
  logic [1:0] full;
  logic [DLY_W-1:0] dly_cnt;
  logic [ADDR_W-1:0] ridx;
  logic [DATA_W-1:0] q;
  logic trig_edge, accept, rd_done, bank_free, cap, wlast, rd_en;
  logic [ADDR_W:0] raddr;
  assign trig_edge = trigger & ~trig_d;
  assign accept = out_valid & out_ready;
  assign rd_done = rs == R_STREAM & accept & ridx == LAST;
  // a bank the reader releases this very cycle already counts as free
  assign bank_free = ~full[wbank] | (rd_done & rbank == wbank);
  // the strobe that lands when the delay count matches is the first stored sample
  assign cap = adc_valid & (ws == W_CAPTURE | (ws == W_DELAY & dly_cnt == trig_delay));
  assign wlast = cap & sample_pos == LAST;
  assign rd_en = rs == R_FETCH | (rs == R_STREAM & accept & ridx != LAST);
  assign raddr = {rbank, (rs == R_FETCH ? ADDR_W'(0) : ridx + 1'b1)};
  assign acq_busy = ws != W_IDLE;
  assign out_sof = out_valid & ridx == '0;
  assign out_eof = out_valid & ridx == LAST;
  assign out_data = out_valid ? (fmt_lat ? {~q[DATA_W-1], q[DATA_W-2:0]} : q) : '0;
  aline_dpram #(.DATA_W(DATA_W), .AW(ADDR_W + 1)) u_ram (
    .clk_system(clk_system),
    .we(cap),
    .waddr({wbank, sample_pos}),
    .wdata(adc_data),
    .re(rd_en),
    .raddr(raddr),
    .rdata(q)
  );
  always_ff @(posedge clk_system) begin
    if (!global_reset) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
      trig_d <= 1'b0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      fmt_lat <= 1'b0;
      full <= '0;
      dly_cnt <= '0;
      ridx <= '0;
      out_valid <= 1'b0;
      sample_pos <= '0;
      overrun_cnt <= '0;
    end else begin
      trig_d <= trigger;
      case (ws)
        W_IDLE: if (trig_edge & enable) begin
          if (bank_free) begin
            ws <= W_DELAY;
            dly_cnt <= '0;
          end else if (~&overrun_cnt) overrun_cnt <= overrun_cnt + 1'b1;
        end
        W_DELAY: if (dly_cnt == trig_delay) ws <= W_CAPTURE;
                 else if (adc_valid) dly_cnt <= dly_cnt + 1'b1;
        default: ;
      endcase
      if (cap) sample_pos <= wlast ? '0 : sample_pos + 1'b1;
      if (wlast) begin
        ws <= W_IDLE;
        wbank <= ~wbank;
      end
      full <= (full | (wlast ? 2'b01 << wbank : 2'b00)) & ~(rd_done ? 2'b01 << rbank : 2'b00);
      case (rs)
        R_IDLE: if (full[rbank]) rs <= R_FETCH;
        R_FETCH: begin
          rs <= R_STREAM;
          out_valid <= 1'b1;
          ridx <= '0;
          fmt_lat <= fmt_offset;
        end
        R_STREAM: if (accept) begin
          if (ridx == LAST) begin
            out_valid <= 1'b0;
            rbank <= ~rbank;
            rs <= R_IDLE;
          end else ridx <= ridx + 1'b1;
        end
        default: rs <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aline_acq_pingpong.sv
// tb_aline_acq_pingpong: randomized scenario tasks checked against a queue-based A-line model
module tb_aline_acq_pingpong;
  localparam int DW = 14, N = 8, AW = 3, DLW = 8, OW = 16;
  logic clk_system = 0, global_reset = 0, enable = 0, trigger = 0, fmt_offset = 0;
  logic adc_valid = 0, out_ready = 0;
  logic [DLW-1:0] trig_delay = '0;
  logic [DW-1:0] adc_data = '0;
  logic out_valid, out_sof, out_eof, acq_busy;
  logic [DW-1:0] out_data;
  logic [AW-1:0] sample_pos;
  logic [OW-1:0] overrun_cnt;
  int n_chk = 0, n_fail = 0, hold_err = 0, n_eof = 0, cyc = 0, ready_mode = 0;
  logic [DW-1:0] rx_d[$], exp_d[$];
  bit rx_s[$], rx_e[$], exp_s[$], exp_e[$];
  int rx_c[$];
  logic pv = 0, pr = 0, ps = 0, pe = 0;
  logic [DW-1:0] pd = '0;

  aline_acq_pingpong #(.DATA_W(DW), .NSAMPLES(N), .ADDR_W(AW), .DLY_W(DLW), .OVR_W(OW)) dut (
    .clk_system(clk_system), .global_reset(global_reset), .enable(enable), .trigger(trigger),
    .trig_delay(trig_delay), .fmt_offset(fmt_offset), .adc_valid(adc_valid), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
    .out_eof(out_eof), .sample_pos(sample_pos), .acq_busy(acq_busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk_system = ~clk_system;
  always @(posedge clk_system) cyc <= cyc + 1;
  always @(posedge clk_system) begin
    #1;
    if (ready_mode == 1) out_ready = ~out_ready;
    else if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
  end

  // records accepted beats and flags any stalled beat that changed before acceptance
  always @(negedge clk_system) begin
    if (!global_reset) pv = 0;
    else begin
      if (pv && !pr && !(out_valid && out_data == pd && out_sof == ps && out_eof == pe)) hold_err++;
      if (out_valid && out_ready) begin
        rx_d.push_back(out_data); rx_s.push_back(out_sof); rx_e.push_back(out_eof); rx_c.push_back(cyc);
        if (out_eof) n_eof++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; ps = out_sof; pe = out_eof;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got time %0t, want < 600000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_system); #2;
  endtask

  task automatic clear_q();
    rx_d.delete(); rx_s.delete(); rx_e.delete(); rx_c.delete();
    exp_d.delete(); exp_s.delete(); exp_e.delete();
  endtask

  // expected A-line: skip dly strobes, keep the next N; offset binary = two's complement + half range
  function automatic void model_line(input logic [DW-1:0] v[$], input int dly, input bit fmt);
    for (int i = 0; i < N; i++) begin
      exp_d.push_back(DW'(v[dly + i] + (fmt ? 14'h2000 : 14'h0000)));
      exp_s.push_back(i == 0);
      exp_e.push_back(i == N - 1);
    end
  endfunction

  function automatic void rand_vals(output logic [DW-1:0] v[$], input int n);
    v.delete();
    for (int i = 0; i < n; i++) v.push_back(DW'($urandom));
  endfunction

  task automatic trig_pulse();
    trigger = 1; tick(); trigger = 0;
  endtask

  task automatic stream(input logic [DW-1:0] v[$], input int maxgap);
    foreach (v[i]) begin
      adc_valid = 0; adc_data = DW'($urandom);
      repeat ($urandom_range(0, maxgap)) tick();
      adc_valid = 1; adc_data = v[i]; tick();
    end
    adc_valid = 0;
  endtask

  task automatic drain(output bit to);
    int k = 0;
    while ((rx_d.size() < exp_d.size() || acq_busy || out_valid) && k < 500) begin tick(); k++; end
    repeat (3) tick();
    to = (k >= 500);
  endtask

  task automatic test_reset();
    global_reset = 0; enable = 1; trigger = 1; adc_valid = 1; adc_data = DW'($urandom); out_ready = 1;
    repeat (3) tick();
    trigger = 0; adc_valid = 0;
    n_chk++;
    if ({out_valid, out_sof, out_eof, acq_busy, out_data, sample_pos, overrun_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h pos=%0d busy=%b ovr=%0d, want all 0",
               out_valid, out_data, sample_pos, acq_busy, overrun_cnt);
    end
    global_reset = 1; tick();
  endtask

  task automatic test_ramp();
    logic [DW-1:0] v[$];
    bit to;
    int span;
    clear_q(); ready_mode = 0; out_ready = 1; trig_delay = 0; fmt_offset = 0;
    for (int i = 0; i < N; i++) v.push_back(DW'(i));
    model_line(v, 0, 0);
    trig_pulse(); stream(v, 0); drain(to);
    n_chk++;
    if (to || rx_d.size() != exp_d.size()) begin n_fail++; $display("FAIL ramp_count: got %0d (timeout=%0b), want %0d", rx_d.size(), to, exp_d.size()); end
    foreach (exp_d[i]) begin
      n_chk++;
      if (rx_d[i] !== exp_d[i] || rx_s[i] !== exp_s[i] || rx_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL ramp[%0d]: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    span = rx_c.size() > 0 ? rx_c[rx_c.size() - 1] - rx_c[0] : -1;
    n_chk++;
    if (span != N - 1) begin n_fail++; $display("FAIL ramp_no_gaps: got span %0d cycles, want %0d", span, N - 1); end
  endtask

  task automatic test_delay();
    logic [DW-1:0] v[$];
    bit to;
    clear_q(); trig_delay = 3;
    for (int i = 0; i <= 10; i++) v.push_back(DW'(i));
    model_line(v, 3, 0);
    trig_pulse(); stream(v, 0); drain(to);
    n_chk++;
    if (to || rx_d.size() != exp_d.size()) begin n_fail++; $display("FAIL delay_count: got %0d (timeout=%0b), want %0d", rx_d.size(), to, exp_d.size()); end
    foreach (exp_d[i]) begin
      n_chk++;
      if (rx_d[i] !== exp_d[i] || rx_s[i] !== exp_s[i] || rx_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL delay[%0d]: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_fmt();
    logic [DW-1:0] v[$];
    bit to;
    clear_q(); trig_delay = 0; fmt_offset = 1;
    for (int i = 0; i < N; i++) v.push_back(i % 2 ? 14'h3FFF : 14'h0000);
    model_line(v, 0, 1);
    trig_pulse(); stream(v, 1); drain(to);
    fmt_offset = 0;
    n_chk++;
    if (to || rx_d.size() != exp_d.size()) begin n_fail++; $display("FAIL fmt_count: got %0d (timeout=%0b), want %0d", rx_d.size(), to, exp_d.size()); end
    foreach (exp_d[i]) begin
      n_chk++;
      if (rx_d[i] !== exp_d[i] || rx_s[i] !== exp_s[i] || rx_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL fmt[%0d]: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] v[$];
    bit to;
    clear_q(); out_ready = 0; trig_delay = 0;
    for (int k = 0; k < 3; k++) begin
      rand_vals(v, N);
      if (k < 2) model_line(v, 0, 0);
      trig_pulse(); stream(v, 1); tick();
    end
    n_chk++;
    if (overrun_cnt !== 16'd1 || sample_pos !== '0 || acq_busy !== 1'b0) begin
      n_fail++; $display("FAIL overrun_state: got ovr=%0d pos=%0d busy=%b, want 1 0 0", overrun_cnt, sample_pos, acq_busy);
    end
    n_chk++;
    if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_data !== exp_d[0]) begin
      n_fail++; $display("FAIL overrun_stall: got v=%b sof=%b d=%h, want 1 1 %h", out_valid, out_sof, out_data, exp_d[0]);
    end
    out_ready = 1; drain(to);
    n_chk++;
    if (to || rx_d.size() != exp_d.size()) begin n_fail++; $display("FAIL overrun_count: got %0d (timeout=%0b), want %0d", rx_d.size(), to, exp_d.size()); end
    foreach (exp_d[i]) begin
      n_chk++;
      if (rx_d[i] !== exp_d[i] || rx_s[i] !== exp_s[i] || rx_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL overrun[%0d]: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_ready_toggle();
    logic [DW-1:0] v[$];
    bit to;
    int dly;
    clear_q(); hold_err = 0; ready_mode = 1;
    for (int k = 0; k < 2; k++) begin
      dly = $urandom_range(0, 2); trig_delay = DLW'(dly);
      rand_vals(v, dly + N);
      model_line(v, dly, 0);
      trig_pulse(); stream(v, 1);
    end
    drain(to); ready_mode = 0; out_ready = 1;
    n_chk++;
    if (to || rx_d.size() != exp_d.size()) begin n_fail++; $display("FAIL toggle_count: got %0d (timeout=%0b), want %0d", rx_d.size(), to, exp_d.size()); end
    foreach (exp_d[i]) begin
      n_chk++;
      if (rx_d[i] !== exp_d[i] || rx_s[i] !== exp_s[i] || rx_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL toggle[%0d]: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    n_chk++;
    if (hold_err != 0) begin n_fail++; $display("FAIL toggle_hold: got %0d unstable stalls, want 0", hold_err); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v[$];
    bit to;
    int dly, base, k;
    clear_q(); hold_err = 0; ready_mode = 2; base = n_eof;
    for (int l = 0; l < 6; l++) begin
      k = 0;
      while (l - (n_eof - base) > 1 && k < 1000) begin tick(); k++; end
      dly = $urandom_range(0, 5); trig_delay = DLW'(dly);
      rand_vals(v, dly + N + 2);
      model_line(v, dly, 0);
      trig_pulse(); stream(v, 2);
    end
    drain(to); ready_mode = 0; out_ready = 1;
    n_chk++;
    if (to || rx_d.size() != exp_d.size()) begin n_fail++; $display("FAIL b2b_count: got %0d (timeout=%0b), want %0d", rx_d.size(), to, exp_d.size()); end
    foreach (exp_d[i]) begin
      n_chk++;
      if (rx_d[i] !== exp_d[i] || rx_s[i] !== exp_s[i] || rx_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL b2b[%0d]: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    n_chk++;
    if (hold_err != 0 || overrun_cnt !== 16'd1) begin
      n_fail++; $display("FAIL b2b_status: got hold_err=%0d ovr=%0d, want 0 1", hold_err, overrun_cnt);
    end
  endtask

  task automatic test_enable();
    logic [DW-1:0] v[$];
    bit to;
    clear_q(); trig_delay = 0; enable = 0;
    rand_vals(v, N);
    trig_pulse(); stream(v, 0); repeat (10) tick();
    n_chk++;
    if (rx_d.size() != 0 || acq_busy !== 1'b0 || overrun_cnt !== 16'd1) begin
      n_fail++; $display("FAIL disabled_idle: got %0d samples busy=%b ovr=%0d, want 0 0 1", rx_d.size(), acq_busy, overrun_cnt);
    end
    enable = 1; rand_vals(v, N); model_line(v, 0, 0);
    trig_pulse(); stream(v[0:3], 0); enable = 0; stream(v[4:7], 0); drain(to); enable = 1;
    n_chk++;
    if (to || rx_d.size() != exp_d.size()) begin n_fail++; $display("FAIL enable_drop_count: got %0d (timeout=%0b), want %0d", rx_d.size(), to, exp_d.size()); end
    foreach (exp_d[i]) begin
      n_chk++;
      if (rx_d[i] !== exp_d[i] || rx_s[i] !== exp_s[i] || rx_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL enable_drop[%0d]: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v[$];
    bit to;
    clear_q(); trig_delay = 0; out_ready = 1;
    rand_vals(v, N);
    trig_pulse(); stream(v[0:3], 0);
    n_chk++;
    if (sample_pos !== 3'd4 || acq_busy !== 1'b1) begin n_fail++; $display("FAIL midline_pos: got pos=%0d busy=%b, want 4 1", sample_pos, acq_busy); end
    global_reset = 0; tick();
    n_chk++;
    if ({out_valid, out_sof, out_eof, acq_busy, out_data, sample_pos, overrun_cnt} !== '0) begin
      n_fail++; $display("FAIL midline_reset: got v=%b d=%h pos=%0d busy=%b ovr=%0d, want all 0",
                         out_valid, out_data, sample_pos, acq_busy, overrun_cnt);
    end
    global_reset = 1; stream(v[4:7], 0); repeat (20) tick();
    n_chk++;
    if (rx_d.size() != 0) begin n_fail++; $display("FAIL midline_discard: got %0d samples, want 0", rx_d.size()); end
    rand_vals(v, N); model_line(v, 0, 0);
    trig_pulse(); stream(v, 1); drain(to);
    n_chk++;
    if (to || rx_d.size() != exp_d.size()) begin n_fail++; $display("FAIL post_reset_count: got %0d (timeout=%0b), want %0d", rx_d.size(), to, exp_d.size()); end
    foreach (exp_d[i]) begin
      n_chk++;
      if (rx_d[i] !== exp_d[i] || rx_s[i] !== exp_s[i] || rx_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL post_reset[%0d]: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b", i, rx_d[i], rx_s[i], rx_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_delay();
    test_fmt();
    test_overrun();
    test_ready_toggle();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
